// File: rtl/ascon_pack.sv
// Shared types and constants for the ASCON permutation datapath and its sequencer.
package ascon_pack;

  // Word 0 is x0 and occupies the most significant 64 bits of the flat vector.
  typedef logic [0:4][63:0] type_state;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_state_t;

  localparam logic [3:0] ROUND_LAST = 4'd11;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  function automatic logic [7:0] round_const(input logic [3:0] r);
    return {~r, r};
  endfunction

endpackage

// File: rtl/permutation_round.sv
// One combinational ASCON round: constant addition, substitution, linear diffusion.
module permutation_round
  import ascon_pack::*;
(
  input  type_state  state_i,
  input  logic [3:0] round_i,
  output type_state  state_o
);

  type_state added;
  type_state subst;

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  always_comb begin
    added          = state_i;
    added[2][7:0]  = state_i[2][7:0] ^ round_const(round_i);
  end

  substitution_layer u_sbox (
    .state_i (added),
    .state_o (subst)
  );

  always_comb begin
    state_o    = subst;
    state_o[0] = subst[0] ^ ror(subst[0], 19) ^ ror(subst[0], 28);
    state_o[1] = subst[1] ^ ror(subst[1], 61) ^ ror(subst[1], 39);
    state_o[2] = subst[2] ^ ror(subst[2], 1)  ^ ror(subst[2], 6);
    state_o[3] = subst[3] ^ ror(subst[3], 10) ^ ror(subst[3], 17);
    state_o[4] = subst[4] ^ ror(subst[4], 7)  ^ ror(subst[4], 41);
  end

endmodule

// File: rtl/substitution_layer.sv
// ASCON 5-bit S-box applied to all 64 bit-slices; x0 is the slice MSB.
module substitution_layer
  import ascon_pack::*;
(
  input  type_state state_i,
  output type_state state_o
);

  for (genvar i = 0; i < 64; i++) begin : g_slice
    logic [4:0] slice_in;
    logic [4:0] slice_out;

    assign slice_in  = {state_i[0][i], state_i[1][i], state_i[2][i], state_i[3][i], state_i[4][i]};
    assign slice_out = SBOX[slice_in];

    assign state_o[0][i] = slice_out[4];
    assign state_o[1][i] = slice_out[3];
    assign state_o[2][i] = slice_out[2];
    assign state_o[3][i] = slice_out[1];
    assign state_o[4][i] = slice_out[0];
  end

endmodule

// File: rtl/permutation_ctrl.sv
// Round sequencer for ASCON p^a / p^b: state register, round counter and handshake FSM.
//   state | meaning
//   IDLE  | ready for start_i, counter parked at 0
//   RUN   | one round per clock, counter walks up to ROUND_LAST
//   DONE  | result held on state_o until out_ready_i
module permutation_ctrl
  import ascon_pack::*;
#(
  parameter int NB_ROUNDS_A = 12,
  parameter int NB_ROUNDS_B = 6
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       mode_b_i,
  input  type_state  state_i,
  output logic       ready_o,
  output logic       valid_o,
  input  logic       out_ready_i,
  output type_state  state_o,
  output logic [3:0] round_o
);

  // Both permutations end on round ROUND_LAST, so the shorter one starts later.
  localparam logic [3:0] CNT_START_A = 4'(int'(ROUND_LAST) + 1 - NB_ROUNDS_A);
  localparam logic [3:0] CNT_START_B = 4'(int'(ROUND_LAST) + 1 - NB_ROUNDS_B);

  ctrl_state_t fsm_q, fsm_d;
  type_state   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  type_state   round_out;

  permutation_round u_round (
    .state_i (state_q),
    .round_i (cnt_q),
    .state_o (round_out)
  );

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (cnt_q > ROUND_LAST) begin
      fsm_d = IDLE;
      cnt_d = '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (start_i) begin
            state_d = state_i;
            cnt_d   = mode_b_i ? CNT_START_B : CNT_START_A;
            fsm_d   = RUN;
          end
        end
        RUN: begin
          state_d = round_out;
          if (cnt_q == ROUND_LAST) begin
            fsm_d = DONE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            fsm_d = IDLE;
            cnt_d = '0;
          end
        end
        default: begin
          fsm_d = IDLE;
          cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      cnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready_o = (fsm_q == IDLE);
  assign valid_o = (fsm_q == DONE);
  assign state_o = state_q;
  assign round_o = cnt_q;

endmodule

// File: tb/tb_permutation_ctrl.sv
// Self-checking bench for permutation_ctrl against a word-level ASCON reference model.
module tb_permutation_ctrl;

  logic         clk;
  logic         reset_i;
  logic         start_i;
  logic         mode_b_i;
  logic [319:0] state_i;
  logic         ready_o;
  logic         valid_o;
  logic         out_ready_i;
  logic [319:0] state_o;
  logic [3:0]   round_o;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam logic [319:0] VEC =
    320'h00001000808c00016cb10ad9ca912f80691aed630e8190ef0c4c36a20853217c46487b3e06d9d7a8;

  permutation_ctrl dut (
    .clock_i     (clk),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .mode_b_i    (mode_b_i),
    .state_i     (state_i),
    .ready_o     (ready_o),
    .valid_o     (valid_o),
    .out_ready_i (out_ready_i),
    .state_o     (state_o),
    .round_o     (round_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (bit-sliced ASCON as in the C reference) ----------------
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] model_rc(input int r);
    return 64'(((15 - r) << 4) | r);
  endfunction

  function automatic logic [319:0] model_sbox(input logic [319:0] s);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s[319:256]; x1 = s[255:192]; x2 = s[191:128]; x3 = s[127:64]; x4 = s[63:0];
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic logic [319:0] model_round(input logic [319:0] s, input int r);
    logic [319:0] t;
    logic [63:0] x0, x1, x2, x3, x4;
    t = s;
    t[191:128] = t[191:128] ^ model_rc(r);
    t = model_sbox(t);
    x0 = t[319:256]; x1 = t[255:192]; x2 = t[191:128]; x3 = t[127:64]; x4 = t[63:0];
    x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
    x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
    x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
    x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
    x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic logic [319:0] model_perm(input logic [319:0] s, input logic mb);
    logic [319:0] t;
    t = s;
    for (int r = (mb ? 6 : 0); r < 12; r++) t = model_round(t, r);
    return t;
  endfunction

  // Runs one 5-bit value through slice 0 of the model S-box.
  function automatic logic [4:0] model_sbox5(input logic [4:0] v);
    logic [319:0] s, o;
    s = '0;
    s[256] = v[4]; s[192] = v[3]; s[128] = v[2]; s[64] = v[1]; s[0] = v[0];
    o = model_sbox(s);
    return {o[256], o[192], o[128], o[64], o[0]};
  endfunction

  // ---------------- cycle model: expected outputs after every edge ----------------
  bit           m_known = 1'b0;
  logic         m_ready, m_valid;
  logic [319:0] m_state;
  int           m_rnd, m_left;

  always @(posedge clk) begin
    if (reset_i) begin
      m_known = 1'b1; m_ready = 1'b1; m_valid = 1'b0;
      m_state = '0; m_rnd = 0; m_left = 0;
    end else if (m_known) begin
      if (m_ready) begin
        if (start_i) begin
          m_ready = 1'b0;
          m_state = state_i;
          m_rnd   = mode_b_i ? 6 : 0;
          m_left  = mode_b_i ? 6 : 12;
        end
      end else if (m_left > 0) begin
        m_state = model_round(m_state, m_rnd);
        if (m_rnd < 11) m_rnd++;
        m_left--;
        if (m_left == 0) m_valid = 1'b1;
      end else if (out_ready_i) begin
        m_valid = 1'b0;
        m_ready = 1'b1;
        m_rnd   = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      check("cyc_ready", ready_o, m_ready);
      check("cyc_valid", valid_o, m_valid);
      check("cyc_round", round_o, m_rnd);
      check("cyc_state", state_o, m_state);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic run_perm(input logic [319:0] s, input logic mb, input bit handoff);
    int cyc;
    int lat;
    logic [319:0] exp;
    exp = model_perm(s, mb);
    lat = mb ? 7 : 13;
    state_i  = s;
    mode_b_i = mb;
    start_i  = 1'b1;
    @(negedge clk);
    cyc = 1;
    start_i = 1'b0;
    check("accepted", ready_o, 1'b0);
    check("first_round", round_o, mb ? 4'd6 : 4'd0);
    while (!valid_o && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, lat);
    check("result", state_o, exp);
    if (handoff) begin
      out_ready_i = 1'b1;
      @(negedge clk);
      out_ready_i = 1'b0;
      check("handoff_ready", ready_o, 1'b1);
      check("handoff_valid", valid_o, 1'b0);
    end
  endtask

  initial begin
    logic [319:0] snap;
    logic [319:0] rs;
    int k;

    reset_i = 1'b1; start_i = 1'b1; mode_b_i = 1'b0; state_i = VEC; out_ready_i = 1'b0;

    // Pin the reference model on hand-known values.
    check("pin_sbox_00", model_sbox5(5'h00), 5'h04);
    check("pin_sbox_01", model_sbox5(5'h01), 5'h0b);
    check("pin_sbox_0a", model_sbox5(5'h0a), 5'h08);
    check("pin_sbox_1f", model_sbox5(5'h1f), 5'h17);
    check("pin_rc_0", model_rc(0), 64'hf0);
    check("pin_rc_1", model_rc(1), 64'he1);
    check("pin_rc_6", model_rc(6), 64'h96);
    check("pin_rc_11", model_rc(11), 64'h4b);
    check("pin_rotr", rotr(64'h1, 1), 64'h8000000000000000);

    // Reset held for two cycles with start asserted.
    repeat (2) @(negedge clk);
    check("rst_ready", ready_o, 1'b1);
    check("rst_valid", valid_o, 1'b0);
    check("rst_state", state_o, 320'h0);
    check("rst_round", round_o, 4'd0);
    reset_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    check("post_rst_idle", ready_o, 1'b1);

    run_perm(VEC, 1'b0, 1'b1);
    run_perm(VEC, 1'b1, 1'b1);

    // Back-pressure in DONE with start pulses.
    run_perm(VEC, 1'b0, 1'b0);
    snap = model_perm(VEC, 1'b0);
    for (int i = 0; i < 20; i++) begin
      start_i  = i[0];
      mode_b_i = i[1];
      state_i  = ~VEC;
      @(negedge clk);
      check("bp_state", state_o, snap);
      check("bp_valid", valid_o, 1'b1);
      check("bp_ready", ready_o, 1'b0);
    end
    start_i = 1'b0;
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
    check("bp_release_ready", ready_o, 1'b1);
    check("bp_release_valid", valid_o, 1'b0);
    @(negedge clk);
    run_perm(VEC, 1'b1, 1'b1);

    // Reset in the middle of a p^a run.
    state_i = VEC; mode_b_i = 1'b0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    k = 0;
    while (round_o != 4'd5 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("mid_reach_r5", round_o, 4'd5);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    check("mid_rst_ready", ready_o, 1'b1);
    check("mid_rst_valid", valid_o, 1'b0);
    check("mid_rst_state", state_o, 320'h0);
    check("mid_rst_round", round_o, 4'd0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("mid_no_valid", valid_o, 1'b0);
    end

    // Back-to-back random runs.
    for (int n = 0; n < 100; n++) begin
      rs = {$urandom, $urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom, $urandom};
      run_perm(rs, 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/permutation_ctrl.md
Name: permutation_ctrl

Overview:
Sequencer for the ASCON permutation p^a (12 rounds) and p^b (6 rounds) built from one round of combinational logic: constant addition, substitution layer and linear diffusion.
- Holds the 320-bit state register and the round counter, and runs one round per clock cycle.
- Handshakes with the mode FSM (initialisation, associated data, plaintext, finalisation) through a start/ready input side and a valid/ready output side.

Parameters:
- NB_ROUNDS_A, 12, round count for p^a.
- NB_ROUNDS_B, 6, round count for p^b; must be ≤ NB_ROUNDS_A.

Ports:
- clock_i  in  1  system clock; all registers update on the rising edge.
- reset_i  in  1  synchronous reset, active-high.
- start_i  in  1  request to run a permutation; sampled only when ready_o=1.
- mode_b_i  in  1  0 = p^a (12 rounds), 1 = p^b (6 rounds); sampled with start_i.
- state_i  in  320 (type_state)  input state x0..x4; sampled with start_i.
- ready_o  out  1  block is idle and accepts start_i.
- valid_o  out  1  state_o holds a finished permutation result.
- out_ready_i  in  1  consumer accepts the result.
- state_o  out  320 (type_state)  state register, driven continuously.
- round_o  out  4  current round index, for debug and coverage.

Behaviour:
- Reset values, applied synchronously while reset_i=1 and overriding every other input:
  - FSM = IDLE, state register = 0, round counter = 0.
  - ready_o=1, valid_o=0, state_o=0, round_o=0.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - ready_o=1, valid_o=0.
  - On start_i=1 at edge T: state_reg <= state_i; cnt <= 0 for p^a, or cnt <= 12 - NB_ROUNDS_B (= 6) for p^b; FSM -> RUN.
- RUN:
  - ready_o=0, valid_o=0.
  - Each edge: state_reg <= round(state_reg, cnt).
  - While cnt < 11: cnt <= cnt + 1. At cnt = 11: cnt unchanged and FSM -> DONE.
  - start_i is ignored throughout RUN.
- Latency from the accepting edge T:
  - p^a: 12 round edges; valid_o=1 in the cycle after edge T+12.
  - p^b: valid_o=1 in the cycle after edge T+6.
- DONE:
  - valid_o=1, ready_o=0; state_o stable.
  - On out_ready_i=1: FSM -> IDLE and cnt <= 0. ready_o becomes 1 on the next cycle.
  - With out_ready_i=0, DONE is held indefinitely and start_i is ignored.
  - No same-cycle DONE -> RUN bypass: a new start_i is accepted no earlier than one cycle after the result handoff.
- Round function round(S, r):
  - Constant addition: x2[7:0] ^= {~r[3:0], r[3:0]}, i.e. 0xF0 at r=0, 0xE1 at r=1, 0x96 at r=6, 0x4B at r=11. The other bits of x2 and x0, x1, x3, x4 are unchanged.
  - Substitution: 5-bit ASCON S-box applied to each of the 64 bit-slices, with x0 as the MSB of the slice index.
  - Linear diffusion:
    - x0 ^= (x0>>>19) ^ (x0>>>28)
    - x1 ^= (x1>>>61) ^ (x1>>>39)
    - x2 ^= (x2>>>1) ^ (x2>>>6)
    - x3 ^= (x3>>>10) ^ (x3>>>17)
    - x4 ^= (x4>>>7) ^ (x4>>>41)
    - All are 64-bit right rotations.
- Round counter:
  - 4 bits; never exceeds 11 and never wraps.
  - Values 12–15 are unreachable; if one occurs, FSM -> IDLE and cnt <= 0.
- Reset during RUN or DONE aborts the permutation. No valid_o pulse is produced; outputs take reset values on the following cycle.
- If reset_i=1 and start_i=1 in the same cycle, reset wins and the start request is dropped.

Decomposition:
- ascon_pack holds:
  - type_state (5 x 64-bit words).
  - ctrl_state_t enum {IDLE, RUN, DONE}.
  - ROUND_LAST = 4'd11.
  - The function round_const(r) returning {~r, r}.
  - The 32-entry S-box lookup constant.
- One combinational sub-module, permutation_round, with ports state_i, round_i, state_o. It chains constant addition, substitution and linear diffusion.
- The existing substitution-layer module is reused inside permutation_round.
- permutation_ctrl contains only the FSM, the counter and the state register.

Test Plan:
- Reset behaviour: apply reset_i=1 for 2 cycles with start_i=1 -> ready_o=1, valid_o=0, state_o=0, round_o=0 throughout, and no start is accepted.
- p^a latency: state_i = 320'h00001000808c00016cb10ad9ca912f80691aed630e8190ef0c4c36a20853217c46487b3e06d9d7a8 with mode_b_i=0 -> round_o steps 0..11, valid_o rises exactly 13 cycles after start, and state_o equals the SV golden model of 12 rounds.
- p^b: the same input with mode_b_i=1 -> round_o steps 6..11, valid_o rises 7 cycles after start, and state_o matches the golden model for rounds 6–11 (first constant 0x96).
- Output back-pressure: hold out_ready_i=0 for 20 cycles in DONE while pulsing start_i -> state_o stable, valid_o stays 1, no restart. Then set out_ready_i=1 -> IDLE next cycle, and a start two cycles later is accepted.
- Reset mid-run: assert reset_i at round_o=5 of a p^a run -> next cycle IDLE with state_o=0, and valid_o never pulses.
- Back-to-back runs: 100 random states with random modes, restarting immediately after each handoff -> every result matches the golden model and every run has the exact latency above.
